fpu_cvt_s_w: RTL and testbench



---
 rtl/fpu_cvt_s_w_pkg.sv | 27 ++
 rtl/fpu_cvt_s_w_if.sv | 34 +++
 rtl/fpu_round_pack.sv | 35 +++
 rtl/fpu_cvt_s_w.sv | 111 +++++++++++
 tb/tb_fpu_cvt_s_w.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_cvt_s_w_pkg.sv
// Shared FPU definitions: coprocessor1 op codes, single-precision field constants
// and the state encoding of the integer-to-float conversion engine.
package fpu_cvt_s_w_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    FP_OP_ADD   = 2'd0,
    FP_OP_SUB   = 2'd1,
    FP_OP_CVTSW = 2'd2
  } fp_op_e;

  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_NORM  = 2'd1,
    CVT_ROUND = 2'd2,
    CVT_DONE  = 2'd3
  } cvt_state_e;

  // Two's-complement magnitude; 32'h80000000 maps onto itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/fpu_cvt_s_w_if.sv
// Handshake bundle for the conversion engine: integer operand in, packed single out.
// Both sides follow valid/ready: a transfer happens on a clk edge where valid and ready are both high;
// the source holds valid and data stable until that edge, and the result side holds its data while valid waits on ready.
interface fpu_cvt_s_w_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_res;
  logic        inexact;

  modport master (
    output in_valid,
    input  in_ready,
    output int_data,
    input  out_valid,
    output out_ready,
    input  float_res,
    input  inexact
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  int_data,
    output out_valid,
    input  out_ready,
    output float_res,
    output inexact
  );

endinterface

// File: rtl/fpu_round_pack.sv
// Combinational round-to-nearest-even and field packing of a normalized magnitude
// (leading one at bit 31) into a single-precision word.
module fpu_round_pack
  import fpu_cvt_s_w_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                     sign,
  input  logic [EXP_W-1:0]         exp,
  input  logic [31:0]              mag,
  output logic [EXP_W+MAN_W:0]     res,
  output logic                     inexact
);

  logic [MAN_W-1:0] man;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [MAN_W:0]   man_sum;
  logic [EXP_W-1:0] exp_adj;

  always_comb begin
    man      = mag[30 -: MAN_W];
    guard    = mag[30-MAN_W];
    sticky   = |mag[29-MAN_W:0];
    round_up = guard & (sticky | man[0]);
    // A carry out of the mantissa leaves the stored field at zero and bumps the exponent.
    man_sum  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
    exp_adj  = exp + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
    res      = {sign, exp_adj, man_sum[MAN_W-1:0]};
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fpu_cvt_s_w.sv
// MIPS cvt.s.w engine: signed 32-bit integer to IEEE-754 single, RNE rounding,
// normalizing one bit per cycle behind valid/ready handshakes.
module fpu_cvt_s_w
  import fpu_cvt_s_w_pkg::*;
#(
  parameter int BIAS  = FP_BIAS,
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  fpu_cvt_s_w_if.slave bus,
  output cvt_state_e   fsm_state
);

  localparam logic [EXP_W-1:0] EXP_START = EXP_W'(BIAS + 31);

  cvt_state_e       state_q;
  cvt_state_e       state_d;
  logic             sign_q;
  logic [31:0]      mag_q;
  logic [EXP_W-1:0] exp_q;
  logic [31:0]      res_q;
  logic             inexact_q;
  logic [31:0]      rp_res;
  logic             rp_inexact;

  fpu_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign    (sign_q),
    .exp     (exp_q),
    .mag     (mag_q),
    .res     (rp_res),
    .inexact (rp_inexact)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CVT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero operand is resolved in NORM so it spends one cycle before DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CVT_IDLE: begin
        if (bus.in_valid) state_d = CVT_NORM;
      end
      CVT_NORM: begin
        if (mag_q == 32'd0)   state_d = CVT_DONE;
        else if (mag_q[31])   state_d = CVT_ROUND;
      end
      CVT_ROUND: begin
        state_d = CVT_DONE;
      end
      CVT_DONE: begin
        if (bus.out_ready) state_d = CVT_IDLE;
      end
      default: begin
        state_d = CVT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= '0;
      res_q     <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      case (state_q)
        CVT_IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.int_data[31];
            mag_q  <= abs32(bus.int_data);
            exp_q  <= EXP_START;
          end
        end
        CVT_NORM: begin
          if (mag_q == 32'd0) begin
            res_q     <= 32'd0;
            inexact_q <= 1'b0;
          end else if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        CVT_ROUND: begin
          res_q     <= rp_res;
          inexact_q <= rp_inexact;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == CVT_IDLE);
  assign bus.out_valid = (state_q == CVT_DONE);
  assign bus.float_res = res_q;
  assign bus.inexact   = inexact_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_fpu_cvt_s_w.sv
// Self-checking bench for fpu_cvt_s_w: directed, rounding, random, backpressure,
// reset and back-to-back scenarios against an arithmetic reference model.
module tb_fpu_cvt_s_w;
  import fpu_cvt_s_w_pkg::*;

  logic       clk;
  logic       reset;
  cvt_state_e fsm_state;

  fpu_cvt_s_w_if bus();

  fpu_cvt_s_w dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        exp_ix_q[$];
  int          exp_lat_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic on a 64-bit magnitude, RNE on the discarded remainder.
  function automatic void ref_cvt(input logic [31:0] x, output logic [31:0] f,
                                  output logic ix, output int lat);
    longint          v;
    longint unsigned m, q, rem, half;
    int              e, e0, sh;
    logic            s;
    if (x == 32'd0) begin
      f = 32'd0; ix = 1'b0; lat = 1;
      return;
    end
    s = x[31];
    v = longint'($signed(x));
    m = (v < 0) ? longint'(-v) : longint'(v);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    e0 = e;
    ix = 1'b0;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      ix   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    f   = {s, 8'(e + 127), q[22:0]};
    lat = (31 - e0) + 2;
  endfunction

  task automatic accept(input logic [31:0] x, input logic [31:0] f, input logic ix, input int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.int_data = x;
    exp_q.push_back(f);
    exp_ix_q.push_back(ix);
    exp_lat_q.push_back(lat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_in_ready x=%h: got %b want 0", x, bus.in_ready);
    end
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready cycle=%0d: got %b want 0", lat, bus.in_ready);
      end
    end
  endtask

  task automatic check_out(input string name, input int lat, input bit ok);
    logic [31:0] f;
    logic        ix;
    int          l;
    f  = exp_q.pop_front();
    ix = exp_ix_q.pop_front();
    l  = exp_lat_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: out_valid not seen in %0d cycles, want latency %0d", name, lat, l);
      return;
    end
    if (bus.float_res !== f) begin
      errors++;
      $display("FAIL %s float_res: got %h want %h", name, bus.float_res, f);
    end
    checks++;
    if (bus.inexact !== ix) begin
      errors++;
      $display("FAIL %s inexact: got %b want %b", name, bus.inexact, ix);
    end
    checks++;
    if (lat != l) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, l);
    end
  endtask

  task automatic take(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handoff: out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic convert(input string name, input logic [31:0] x, input logic [31:0] f,
                         input logic ix, input int lat);
    int l;
    bit ok;
    accept(x, f, ix, lat);
    wait_out(l, ok);
    check_out(name, l, ok);
    if (ok) take(name);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.float_res !== 32'h0 ||
        bus.inexact !== 1'b0 || fsm_state !== CVT_IDLE) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b float_res=%h inexact=%b state=%0d want 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.float_res, bus.inexact, fsm_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
    convert("int_1",     32'd1,                32'h3F800000, 1'b0, 33);
    convert("int_m23",   32'hFFFFFFE9,         32'hC1B80000, 1'b0, 2 + 27);
    convert("int_5607",  32'd5607,             32'h45AF3800, 1'b0, 2 + 19);
    convert("int_100",   32'd100,              32'h42C80000, 1'b0, 2 + 25);
    convert("int_min",   32'h80000000,         32'hCF000000, 1'b0, 2);
    convert("int_0",     32'd0,                32'h00000000, 1'b0, 1);
  endtask

  task automatic test_rounding;
    convert("tie_even",  32'h01000001, 32'h4B800000, 1'b1, 9);
    convert("tie_up",    32'h01000003, 32'h4B800002, 1'b1, 9);
    convert("carry_exp", 32'h7FFFFFFF, 32'h4F000000, 1'b1, 3);
  endtask

  task automatic test_random;
    logic [31:0] x, f;
    logic        ix;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
      ref_cvt(x, f, ix, lat);
      convert($sformatf("rand_%0d", i), x, f, ix, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] f;
    logic        ix;
    int          lat, l;
    bit          ok;
    ref_cvt(32'h7FFFFFC1, f, ix, lat);
    accept(32'h7FFFFFC1, f, ix, lat);
    wait_out(l, ok);
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.in_valid = ~bus.in_valid;
        bus.int_data = $urandom();
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
            bus.float_res !== f || bus.inexact !== ix) begin
          errors++;
          $display("FAIL bp_hold cycle=%0d: out_valid=%b in_ready=%b float_res=%h inexact=%b want 1/0/%h/%b",
                   i, bus.out_valid, bus.in_ready, bus.float_res, bus.inexact, f, ix);
        end
      end
      bus.in_valid = 1'b0;
    end
    check_out("bp_result", l, ok);
    if (ok) take("bp_release");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle_after: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_norm;
    accept(32'd1, 32'h3F800000, 1'b0, 33);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.float_res !== 32'h0 ||
        bus.inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_norm: in_ready=%b out_valid=%b float_res=%h inexact=%b want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.float_res, bus.inexact);
    end
    exp_q.delete();
    exp_ix_q.delete();
    exp_lat_q.delete();
    @(negedge clk);
    reset = 1'b0;
    convert("after_reset_2", 32'd2, 32'h40000000, 1'b0, 32);
  endtask

  task automatic test_back_to_back;
    logic [31:0] f;
    logic        ix;
    int          lat, l;
    bit          ok;
    accept(32'd100, 32'h42C80000, 1'b0, 27);
    wait_out(l, ok);
    check_out("b2b_first", l, ok);
    ref_cvt(32'hFFFF0001, f, ix, lat);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.int_data  = 32'hFFFF0001;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_same_cycle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    exp_q.push_back(f);
    exp_ix_q.push_back(ix);
    exp_lat_q.push_back(lat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(l, ok);
    check_out("b2b_second", l, ok);
    if (ok) take("b2b_second");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.int_data  = 32'd0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    test_reset();
    test_directed();
    test_rounding();
    test_random();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
